// File: rtl/uart_command_receiver.sv
// Drive-command UART receiver: 8N1 deserialiser, ASCII-to-command decode, one-deep valid/ready holding register.
// Build option: define UART_RX_PARITY_EN for 8E1 frames (even parity bit before the stop bit).
module uart_command_receiver #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_in,
    output logic [2:0] command,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       framing_error,
    output logic       parity_error,
    output logic       unknown_char,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ASCII code for command gi sits in byte gi: S F B L R C T X
    localparam logic [63:0] CMD_CHARS = {8'h58, 8'h54, 8'h43, 8'h52, 8'h4C, 8'h42, 8'h46, 8'h53};

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK, DECODE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK, DECODE} state_t;
`endif

    state_t           state_reg;
    logic [1:0]       sync_reg;
    logic             rx_s;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             parity_bad_reg;
    logic [2:0]       command_reg;
    logic             valid_reg;
    logic             framing_error_reg;
    logic             parity_error_reg;
    logic             unknown_char_reg;
    logic             overrun_reg;
    logic [7:0]       char_hit;
    logic             map_hit;
    logic [2:0]       map_code;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], uart_in};
        end
    end

    assign rx_s = sync_reg[1];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_map
            assign char_hit[gi] = (shift_reg == CMD_CHARS[gi*8 +: 8]);
        end
    endgenerate

    always_comb begin
        map_hit  = |char_hit;
        map_code = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (char_hit[i]) begin
                map_code = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            bit_idx_reg       <= 3'd0;
            shift_reg         <= 8'd0;
            parity_bad_reg    <= 1'b0;
            command_reg       <= 3'd0;
            valid_reg         <= 1'b0;
            framing_error_reg <= 1'b0;
            parity_error_reg  <= 1'b0;
            unknown_char_reg  <= 1'b0;
            overrun_reg       <= 1'b0;
        end else begin
            framing_error_reg <= 1'b0;
            parity_error_reg  <= 1'b0;
            unknown_char_reg  <= 1'b0;
            overrun_reg       <= 1'b0;

            // Consumption clear comes first so a same-cycle load in DECODE overrides it
            if (valid_reg && cmd_ready) begin
                valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    parity_bad_reg <= 1'b0;
                    if (!rx_s) begin
                        state_reg <= START;
                        cnt_reg   <= HALF_BIT;
                    end
                end
                START: begin
                    if (cnt_reg <= CNT_ONE) begin
                        if (rx_s) begin
                            state_reg <= IDLE;
                        end else begin
                            state_reg   <= DATA;
                            cnt_reg     <= FULL_BIT;
                            bit_idx_reg <= 3'd0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_reg <= CNT_ONE) begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        cnt_reg   <= FULL_BIT;
                        if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_reg <= PARITY;
`else
                            state_reg <= STOP;
`endif
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_reg <= CNT_ONE) begin
                        parity_bad_reg <= (rx_s != ^shift_reg);
                        cnt_reg        <= FULL_BIT;
                        state_reg      <= STOP;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
`endif
                STOP: begin
                    if (cnt_reg <= CNT_ONE) begin
                        if (!rx_s) begin
                            framing_error_reg <= 1'b1;
                            state_reg         <= BREAK;
                        end else if (parity_bad_reg) begin
                            parity_error_reg <= 1'b1;
                            state_reg        <= IDLE;
                        end else begin
                            state_reg <= DECODE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                BREAK: begin
                    // A line stuck low must go high before another start bit counts
                    if (rx_s) begin
                        state_reg <= IDLE;
                    end
                end
                DECODE: begin
                    state_reg <= IDLE;
                    if (map_hit) begin
                        if (!valid_reg || cmd_ready) begin
                            command_reg <= map_code;
                            valid_reg   <= 1'b1;
                        end else begin
                            overrun_reg <= 1'b1;
                        end
                    end else begin
                        unknown_char_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign command       = command_reg;
    assign cmd_valid     = valid_reg;
    assign framing_error = framing_error_reg;
    assign unknown_char  = unknown_char_reg;
    assign overrun       = overrun_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = parity_error_reg;
`else
    assign parity_error  = 1'b0;
`endif

endmodule

// File: doc/uart_command_receiver.md
# uart_command_receiver

- Receive end of the drive-command serial link: deserialises 8N1 UART frames from the `uart_tx` path, decodes the single ASCII command byte back to the 3-bit drive command, and presents it on a valid/ready handshake.
- Sits on the base/robot board between the GPIO receive pin and the motor/drive controller.
- Detects false starts, framing errors, unknown characters and overrun.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 115200, line rate; `CLKS_PER_BIT = CLK_FREQ/BAUD`, truncated (434 at defaults).

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: system clock (clk_50 domain).
- `reset` input 1: asynchronous, active-high; clears all state.
- `uart_in` input 1: serial line, idle high, asynchronous to `clk`.
- `command` output 3: decoded drive command.
- `cmd_valid` output 1: `command` holds an unconsumed command.
- `cmd_ready` input 1: consumer accepts `command` when high together with `cmd_valid`.
- `framing_error` output 1: one-cycle pulse, stop bit sampled low.
- `parity_error` output 1: one-cycle pulse, parity mismatch; constant 0 unless parity is compiled in.
- `unknown_char` output 1: one-cycle pulse, byte received cleanly but not in the command map.
- `overrun` output 1: one-cycle pulse, valid command dropped because the holding register was full.

## Operation
- `uart_in` passes through a 2-flop synchroniser. The synchroniser reset value is 1 (idle).
- All receive logic uses the synchronised signal `rx_s`.
- FSM states:
  - IDLE: on `rx_s` = 0, go to START and load the bit counter with `CLKS_PER_BIT/2` (217).
  - START: at count expiry sample `rx_s`. If 1 (false start), return to IDLE with no pulse. If 0, go to DATA and reload with `CLKS_PER_BIT`.
  - DATA: sample 8 bits, LSB first, one per `CLKS_PER_BIT` at bit centres, into the shift register. After bit 7, go to PARITY (macro on) or STOP.
  - PARITY: sample one bit; even parity over the 8 data bits.
  - STOP: sample at centre.
    - If 1: go to DECODE.
    - If 0: pulse `framing_error`, discard the byte, go to BREAK.
    - If parity was wrong (stop bit good): pulse `parity_error`, discard the byte, go to IDLE.
  - BREAK: wait for `rx_s` = 1, then go to IDLE. This prevents a held-low line retriggering.
  - DECODE: one cycle, then IDLE. A new start bit may be detected from the following cycle.
- Command map (ASCII → `command`): 'S' (0x53) → 0, 'F' (0x46) → 1, 'B' (0x42) → 2, 'L' (0x4C) → 3, 'R' (0x52) → 4, 'C' (0x43) → 5, 'T' (0x54) → 6, 'X' (0x58) → 7. Any other byte pulses `unknown_char` and is discarded.
- Holding register, one deep. In DECODE with a mapped byte:
  - If `cmd_valid` = 0, or `cmd_ready` = 1 in the same cycle: load `command`, set `cmd_valid`.
  - Otherwise keep the old command and pulse `overrun`.
- `cmd_valid` clears on the cycle after `cmd_valid && cmd_ready`, unless a new load happens in that same cycle (load wins).
- `command` is stable while `cmd_valid` = 1.
- Reset mid-frame: FSM → IDLE, partial byte discarded. The first falling edge seen after reset release starts a fresh frame.

## Timing
- Reset values: `command` = 0, `cmd_valid` = 0, all error pulses = 0, FSM = IDLE, synchroniser = 1.
- Start-edge recognition: 2 cycles of synchroniser latency.
- Each sample point: ±1 cycle of the ideal bit centre relative to the synchronised edge.
- `cmd_valid` rises exactly 2 cycles after the stop-bit sample cycle (STOP → DECODE, then register).
- Error pulses assert in the cycle after the offending sample (or after DECODE for `unknown_char` / `overrun`).
- Each error pulse lasts exactly 1 cycle.
- Back-to-back frames are sustained with zero idle time between the stop bit and the next start bit.
- Counter width: `$clog2(CLKS_PER_BIT)+1` bits, counting down and expiring at 1. The counter never wraps.

## Configuration
- `UART_RX_PARITY_EN` defined: 9-bit frame (8 data + even parity) before the stop bit. Mismatch → `parity_error` pulse, byte discarded.
- Undefined: 8N1, PARITY state absent, `parity_error` tied to 0.
- Must match the transmitter's build.

## Test plan
- Reset, line idle, then send 'F' (0x46) at 434 clk/bit → `command` = 1 and `cmd_valid` = 1, 2 cycles after the stop-bit centre; held until `cmd_ready` = 1, clears the next cycle.
- Send 'L' then 'R' back-to-back with `cmd_ready` = 0 → `command` stays 3, one `overrun` pulse; raise ready then resend 'R' → `command` = 4.
- Low glitch on `uart_in` for 100 cycles → no pulse, no `cmd_valid`, FSM back in IDLE; a following 'S' is received as 0.
- Frame 0x53 with stop bit forced low, line held low 5000 cycles → exactly one `framing_error`, no retrigger; 'T' after the line returns high → `command` = 6.
- Send 'Q' (0x51) → one `unknown_char` pulse, `cmd_valid` unchanged. With `UART_RX_PARITY_EN`, 'B' with a flipped parity bit → one `parity_error`, no command.
- Assert `reset` during data bit 4 of 'C', release, send 'C' → only one command, 5; no error pulses.
